// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: issues DIV/DIVU, holds operands,
// stalls the pipeline until the {remainder, quotient} result is captured into HI/LO.
module div_issue_ctrl #(
    parameter int DATA_W        = 32,
    parameter int CANCEL_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_req_i,
    input  logic                div_signed_i,
    input  logic [DATA_W-1:0]   rs_data_i,
    input  logic [DATA_W-1:0]   rt_data_i,
    input  logic                flush_i,
    input  logic                ex_stall_i,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_opdata1_o,
    output logic [DATA_W-1:0]   div_opdata2_o,
    input  logic                div_ready_i,
    input  logic [2*DATA_W-1:0] div_result_i,
    output logic                stallreq_o,
    output logic                result_valid_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, CANCEL} state_t;

    localparam int CNT_W = (CANCEL_CYCLES > 2) ? $clog2(CANCEL_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op1_q, op2_q, hi_q, lo_q;
    logic              signed_q;
    logic [CNT_W-1:0]  cnt_q;

    logic start, annul, stall, valid, pass_inputs;
    logic accept, capture;

    assign accept  = (state_q == IDLE) && div_req_i && !flush_i;
    assign capture = (state_q == BUSY) && div_ready_i && !flush_i;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        annul       = 1'b0;
        stall       = 1'b0;
        valid       = 1'b0;
        pass_inputs = 1'b0;
        unique case (state_q)
            IDLE: begin
                pass_inputs = 1'b1;
                start       = div_req_i && !flush_i;
                stall       = div_req_i && !flush_i;
                if (div_req_i && !flush_i) state_d = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (flush_i) begin
                    annul   = 1'b1;
                    state_d = CANCEL;
                end else begin
                    start = 1'b1;
                    if (div_ready_i) state_d = DONE;
                end
            end
            DONE: begin
                // Dropping start here releases the divider from its end state.
                valid = !flush_i;
                if (!(ex_stall_i && !flush_i)) state_d = IDLE;
            end
            CANCEL: begin
                annul = 1'b1;
                stall = div_req_i;
                if (cnt_q == CNT_W'(CANCEL_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op1_q    <= rs_data_i;
                op2_q    <= rt_data_i;
                signed_q <= div_signed_i;
            end
            if (capture) begin
                hi_q <= div_result_i[2*DATA_W-1:DATA_W];
                lo_q <= div_result_i[DATA_W-1:0];
            end
            cnt_q <= (state_q == CANCEL) ? cnt_q + CNT_W'(1) : '0;
        end
    end

    // Outputs are forced low while rst is held, whatever the inputs are doing.
    assign div_start_o    = start && !rst;
    assign div_annul_o    = annul && !rst;
    assign stallreq_o     = stall && !rst;
    assign result_valid_o = valid && !rst;
    assign div_signed_o   = rst ? 1'b0 : (pass_inputs ? div_signed_i : signed_q);
    assign div_opdata1_o  = rst ? '0 : (pass_inputs ? rs_data_i : op1_q);
    assign div_opdata2_o  = rst ? '0 : (pass_inputs ? rt_data_i : op2_q);
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural multi-cycle divider
// (ready two cycles after start for a zero divisor, 34 cycles otherwise).
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req_i, div_signed_i, flush_i, ex_stall_i;
    logic [31:0] rs_data_i, rt_data_i;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        stallreq_o, result_valid_o;
    logic [31:0] hi_o, lo_o;

    int vectors = 0;
    int errors  = 0;
    int lat, stalls;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DATA_W(32), .CANCEL_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .div_req_i(div_req_i), .div_signed_i(div_signed_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .flush_i(flush_i), .ex_stall_i(ex_stall_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o),
        .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .stallreq_o(stallreq_o), .result_valid_o(result_valid_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    // Divider model: counts start cycles, sits in its end state until start drops.
    int  d_cnt;
    bit  d_end;

    function automatic logic [63:0] divide(input logic [31:0] a, b, input logic sgn);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0)   return 64'd0;
        if (sgn)      return {32'(sa % sb), 32'(sa / sb)};
        return {a % b, a / b};
    endfunction

    always @(posedge clk) begin
        if (rst || !div_start_o || div_annul_o) begin
            d_cnt <= 0;
            d_end <= 1'b0;
        end else if (!d_end) begin
            d_cnt <= d_cnt + 1;
            if (d_cnt + 1 == ((div_opdata2_o == 0) ? 2 : 34)) begin
                d_end        <= 1'b1;
                div_result_i <= divide(div_opdata1_o, div_opdata2_o, div_signed_o);
            end
        end
    end
    assign div_ready_i = d_end;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 of a request: accepted in IDLE, then request dropped at cycle 1.
    task automatic issue(input logic [31:0] a, b, input logic sgn);
        rs_data_i    = a;
        rt_data_i    = b;
        div_signed_i = sgn;
        div_req_i    = 1'b1;
        #1;
        check("start_c0", div_start_o, 1);
        check("stall_c0", stallreq_o, 1);
        step();
        div_req_i = 1'b0;
    endtask

    task automatic run_to_done(input int lat0, input int stall0, output int l, output int s);
        l = lat0;
        s = stall0;
        while (!result_valid_o && l < 100) begin
            if (stallreq_o) s++;
            step();
            l++;
        end
    endtask

    initial begin
        rst = 1'b1; div_req_i = 1'b1; div_signed_i = 1'b1; flush_i = 1'b0;
        ex_stall_i = 1'b0; rs_data_i = 32'd5; rt_data_i = 32'd3;
        div_result_i = '0;
        step(); step();
        check("rst_start", div_start_o, 0);
        check("rst_stall", stallreq_o, 0);
        check("rst_op1", div_opdata1_o, 0);
        check("rst_hilo", {hi_o, lo_o}, 0);
        rst = 1'b0; div_req_i = 1'b0;
        step();

        // Signed -7 / 2
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        check("sgn_held", div_signed_o, 1);
        run_to_done(1, 1, lat, stalls);
        check("s_lat", lat, 35);
        check("s_stalls", stalls, 35);
        check("s_valid", result_valid_o, 1);
        check("s_lo", lo_o, 32'hFFFF_FFFD);
        check("s_hi", hi_o, 32'hFFFF_FFFF);
        check("s_stall_done", stallreq_o, 0);
        step();
        check("s_valid_1cyc", result_valid_o, 0);
        check("s_hi_hold", hi_o, 32'hFFFF_FFFF);

        // Unsigned 100 / 7, operands changed during BUSY
        issue(32'd100, 32'd7, 1'b0);
        rs_data_i = 32'hDEAD_BEEF; rt_data_i = 32'd0; div_signed_i = 1'b1;
        #1;
        check("u_op1_hold", div_opdata1_o, 100);
        check("u_op2_hold", div_opdata2_o, 7);
        check("u_sgn_hold", div_signed_o, 0);
        run_to_done(1, 1, lat, stalls);
        check("u_lat", lat, 35);
        check("u_lo", lo_o, 14);
        check("u_hi", hi_o, 2);
        step();

        // Divide by zero
        issue(32'd5, 32'd0, 1'b0);
        run_to_done(1, 1, lat, stalls);
        check("z_lat", lat, 3);
        check("z_stalls", stalls, 3);
        check("z_hilo", {hi_o, lo_o}, 0);
        check("z_start_done", div_start_o, 0);
        step();
        check("z_div_free", div_ready_i, 0);

        // Flush at cycle 10, then 9 / 3 waiting during CANCEL
        issue(32'd20, 32'd3, 1'b0);
        repeat (9) step();
        flush_i = 1'b1;
        #1;
        check("f10_annul", div_annul_o, 1);
        check("f10_start", div_start_o, 0);
        step();
        flush_i = 1'b0; div_req_i = 1'b1; rs_data_i = 32'd9; rt_data_i = 32'd3;
        div_signed_i = 1'b0;
        #1;
        check("f11_annul", div_annul_o, 1);
        check("f11_start", div_start_o, 0);
        check("f11_stall", stallreq_o, 1);
        check("f11_valid", result_valid_o, 0);
        step();
        check("f12_annul", div_annul_o, 1);
        check("f12_stall", stallreq_o, 1);
        check("f12_valid", result_valid_o, 0);
        step();
        check("f13_annul", div_annul_o, 0);
        check("f13_start", div_start_o, 1);
        check("f13_stall", stallreq_o, 1);
        step();
        div_req_i = 1'b0;
        run_to_done(1, 1, lat, stalls);
        check("f_lat", lat, 35);
        check("f_lo", lo_o, 3);
        check("f_hi", hi_o, 0);
        step();

        // ex_stall extends DONE by 4 cycles; requests during DONE ignored
        issue(32'd50, 32'd5, 1'b0);
        ex_stall_i = 1'b1;
        run_to_done(1, 1, lat, stalls);
        check("e_lat", lat, 35);
        check("e_lo", lo_o, 10);
        for (int i = 0; i < 3; i++) begin
            step();
            div_req_i = 1'b1;
            #1;
            check("e_valid_ext", result_valid_o, 1);
            check("e_lo_ext", lo_o, 10);
            check("e_no_start", div_start_o, 0);
        end
        step();
        ex_stall_i = 1'b0; div_req_i = 1'b0;
        #1;
        check("e_valid_last", result_valid_o, 1);
        step();
        check("e_valid_end", result_valid_o, 0);
        check("e_start_end", div_start_o, 0);
        check("e_stall_end", stallreq_o, 0);

        // Reset at cycle 20 of a divide, then 8 / 2
        issue(32'd1000, 32'd3, 1'b0);
        repeat (19) step();
        rst = 1'b1;
        #1;
        check("r_start_in_rst", div_start_o, 0);
        step();
        rst = 1'b0; rs_data_i = '0; rt_data_i = '0; div_signed_i = 1'b0;
        #1;
        check("r_ctl", {div_start_o, div_annul_o, stallreq_o, result_valid_o, div_signed_o}, 0);
        check("r_ops", {div_opdata1_o, div_opdata2_o}, 0);
        check("r_hilo", {hi_o, lo_o}, 0);
        issue(32'd8, 32'd2, 1'b0);
        run_to_done(1, 1, lat, stalls);
        check("r_lat", lat, 35);
        check("r_lo", lo_o, 4);
        check("r_hi", hi_o, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
